// File: rtl/bounce_pkg.sv
// Shared definitions for the contact-bounce emulator: FSM encoding, LFSR geometry and
// default seed.
package bounce_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } state_t;

  localparam int          LFSR_W       = 8;
  localparam logic [7:0]  LFSR_TAPS    = 8'hB8;  // x^8+x^6+x^5+x^4+1 -> bits 7,5,4,3
  localparam logic [7:0]  DEFAULT_SEED = 8'hA5;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bounce_emulator_lfsr8.sv
// 8-bit Fibonacci LFSR with advance enable; synchronous active-low reset loads SEED.
module lfsr8
  import bounce_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [LFSR_W-1:0] value
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n)  value <= SEED;
    else if (en) value <= lfsr_next(value);
  end

endmodule

// File: rtl/bounce_emulator.sv
// Contact-bounce generator: each level change on clean becomes a BOUNCE_CYC-cycle burst
// of LFSR chatter on noisy, then settles and pulses settled.
module bounce_emulator
  import bounce_pkg::*;
#(
  parameter int                BOUNCE_CYC = 16,
  parameter int                CW         = 5,
  parameter logic [LFSR_W-1:0] SEED       = DEFAULT_SEED
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clean,
  input  logic en,
  output logic noisy,
  output logic busy,
  output logic settled
);

  localparam logic [CW-1:0] CNT_LOAD = CW'(BOUNCE_CYC);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t            state_q, state_d;
  logic              clean_q;
  logic              target_q, target_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              noisy_d, busy_d, settled_d;
  logic              lfsr_adv;
  logic [LFSR_W-1:0] lfsr_val;

  lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lfsr_adv),
    .value (lfsr_val)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    noisy_d   = noisy;
    busy_d    = busy;
    settled_d = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clean_q != target_q) begin
          target_d = clean_q;
          noisy_d  = clean_q;
          if (en) begin
            cnt_d   = CNT_LOAD;
            busy_d  = 1'b1;
            state_d = BOUNCE;
          end
        end
      end
      BOUNCE: begin
        // A new request restarts the burst and wins over the final settle.
        if (clean_q != target_q) begin
          target_d = clean_q;
          noisy_d  = clean_q;
          cnt_d    = CNT_LOAD;
        end else if (cnt_q > CNT_ONE) begin
          noisy_d  = lfsr_val[0];
          cnt_d    = cnt_q - CNT_ONE;
          lfsr_adv = 1'b1;
        end else begin
          noisy_d   = target_q;
          busy_d    = 1'b0;
          settled_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      clean_q  <= 1'b0;
      target_q <= 1'b0;
      cnt_q    <= '0;
      noisy    <= 1'b0;
      busy     <= 1'b0;
      settled  <= 1'b0;
    end else begin
      state_q  <= state_d;
      clean_q  <= clean;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      noisy    <= noisy_d;
      busy     <= busy_d;
      settled  <= settled_d;
    end
  end

endmodule

// File: doc/bounce_emulator.md
# bounce_emulator

Synthesizable contact-bounce generator: converts a clean level request into a chattering output that imitates a mechanical switch. It drives the team's debouncer inputs on-chip, so button-handling paths can be exercised on the FPGA without physical switches. Each level change on `clean` produces a bounce burst from an 8-bit LFSR. The output then settles to the new level, and a one-cycle `settled` pulse is emitted.

## Interface
- `BOUNCE_CYC`, 16: length of a bounce event in cycles, counted from the first contact to the final settle; legal range 1..2^CW-1.
- `CW`, 5: counter width; CW ≥ ceil(log2(BOUNCE_CYC+1)).
- `SEED`, 8'hA5: LFSR reset value; must be nonzero.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `clean` in 1: requested stable level.
- `en` in 1: bounce injection enable; sampled only when an event starts.
- `noisy` out 1: emulated switch output (registered).
- `busy` out 1: high while a bounce event is in progress.
- `settled` out 1: one-cycle pulse when `noisy` takes its final level.

## Operation
- Reset (rst_n=0 at an edge) sets:
  - state=IDLE
  - `clean_q`=0, `target`=0, `cnt`=0, `lfsr`=SEED
  - `noisy`=0, `busy`=0, `settled`=0
- Reset mid-event aborts the event; no `settled` pulse is emitted.
- `clean` is registered once into `clean_q`; the FSM compares only `clean_q` with `target`.
- IDLE, when `clean_q != target`:
  - en=0: `target`←`clean_q`, `noisy`←`clean_q`; stay in IDLE; no `busy`, no `settled`.
  - en=1: `target`←`clean_q`, `noisy`←`clean_q` (first contact), `cnt`←BOUNCE_CYC, `busy`←1, go to BOUNCE.
- BOUNCE, `clean_q == target`, `cnt > 1`: `noisy`←`lfsr[0]`, `cnt`←`cnt-1`, LFSR advances.
- BOUNCE, `clean_q == target`, `cnt == 1`: `noisy`←`target`, `busy`←0, `settled`←1, go to IDLE.
- BOUNCE, `clean_q != target` (retrigger):
  - `target`←`clean_q`, `noisy`←`clean_q`, `cnt`←BOUNCE_CYC.
  - No `settled` pulse; retrigger has priority over `cnt == 1`.
- `en` falling during BOUNCE does not abort the current event.
- `settled` is cleared on every edge where it is not set.
- LFSR:
  - Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Update: `lfsr`←{lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances only on BOUNCE edges with `cnt > 1`; holds otherwise, so sequences continue across events.
- `cnt` never underflows; it is 0 only in IDLE.

## Timing
- Let `clean` change before edge k, so `clean_q` updates at edge k.
- en=0: `noisy` follows `clean` at edge k+1; latency 2 edges.
- en=1:
  - First contact at edge k+1.
  - Pseudo-random values at edges k+2..k+BOUNCE_CYC, i.e. BOUNCE_CYC-1 values.
  - Final level and `settled` at edge k+1+BOUNCE_CYC.
  - `busy` is high for exactly BOUNCE_CYC cycles.
- BOUNCE_CYC=1: no random values; `busy` high 1 cycle; `settled` at edge k+2.
- Pulses on `clean` shorter than one cycle may be missed; this is by design.

## Structure
- Shared package `bounce_pkg` holds:
  - state encoding: IDLE=1'b0, BOUNCE=1'b1
  - LFSR width (8) and tap mask (8'hB8)
  - default SEED
- One natural sub-module: `lfsr8`, with enable and synchronous active-low reset to SEED; output is the full register.
- The FSM, counter and output registers stay in the top module.

## Test plan
- Reset, then BOUNCE_CYC=16, SEED=8'hA5, en=1; `clean` 0→1 before edge k:
  - `noisy`=1 at k+1, then 1 at k+2, 0 at k+3 (LFSR 8'hA5→8'h4A).
  - `noisy`=1 from k+17 onward.
  - `settled` high only at k+17; `busy` high k+1..k+16.
- en=0 with `clean` toggling every 3 cycles: `noisy` equals `clean` delayed 2 cycles; `busy` and `settled` stay 0; LFSR unchanged.
- Retrigger: during the bounce above, return `clean` to 0 at edge k+6:
  - `noisy`=0 at k+7.
  - Final 0 and `settled` at k+7+16=k+23.
  - No `settled` at k+17.
- Apply rst_n=0 at edge k+8 of an event: next cycle `noisy`=0, `busy`=0, `lfsr`=8'hA5; no `settled` pulse.
- BOUNCE_CYC=1, `clean` 0→1: `noisy`=1 at k+1; `busy` high for 1 cycle; `settled` at k+2.
- Loop-back into the debouncer with N=10, BOUNCE_CYC=16, rising event: debounced goes high exactly 10 cycles after `noisy` last rises and never glitches afterwards.
